// File: rtl/pwm_config_scheduler.sv
// -----------------------------------------------------------------------------
// pwm_config_scheduler
//
// Purpose: accepts a new PWM timing set (period plus high-side and low-side
// rise/fall tick numbers), checks that it is ordered sensibly, holds it, and
// copies it to the active outputs at a safe point. Once a set is running,
// the safe point is the last tick of a PWM period, so the PWM generator
// never sees a set change partway through a period. The first set after
// reset goes live straight away because no period is running yet.
//
// Optional feature: define PWM_CONFIG_SCHEDULER_REJECT_COUNT_EN to add the
// 8-bit saturating reject_count output.
//
// Ports:
//   clock                               rising-edge clock
//   reset                               synchronous active-high reset
//   cfg_valid / cfg_ready               offer / accept handshake for a new set
//   cfg_period, cfg_rise_hs, cfg_fall_hs,
//   cfg_rise_ls, cfg_fall_ls            offered set, sampled only when accepted
//   cfg_abort                           drops a staged set while it waits
//   period_end                          last-tick pulse from the PWM counter
//   tick_count_period, tick_number_*    active set sent to the PWM generator
//   configuration_valid                 set once any set has been committed
//   update_strobe                       one-cycle pulse after a commit
//   cfg_rejected                        one-cycle pulse after a failed check
//   pending                             a checked set is waiting to commit
//   reject_count                        (optional) saturating count of rejects
// -----------------------------------------------------------------------------
module pwm_config_scheduler #(
  parameter int bitwidth = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [bitwidth-1:0] cfg_period,
  input  logic [bitwidth-1:0] cfg_rise_hs,
  input  logic [bitwidth-1:0] cfg_fall_hs,
  input  logic [bitwidth-1:0] cfg_rise_ls,
  input  logic [bitwidth-1:0] cfg_fall_ls,
  input  logic                cfg_abort,
  input  logic                period_end,
  output logic [bitwidth-1:0] tick_count_period,
  output logic [bitwidth-1:0] tick_number_rising_edge_highside,
  output logic [bitwidth-1:0] tick_number_falling_edge_highside,
  output logic [bitwidth-1:0] tick_number_rising_edge_lowside,
  output logic [bitwidth-1:0] tick_number_falling_edge_lowside,
  output logic                configuration_valid,
  output logic                update_strobe,
  output logic                cfg_rejected,
`ifdef PWM_CONFIG_SCHEDULER_REJECT_COUNT_EN
  output logic [7:0]          reject_count,
`endif
  output logic                pending
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CHECK   = 2'd1,
    PENDING = 2'd2
  } state_t;

  // Field index order: 0 period, 1 rise_hs, 2 fall_hs, 3 rise_ls, 4 fall_ls
  localparam int NFIELD = 5;

  state_t              state_q, state_d;
  logic [bitwidth-1:0] cfg_in   [NFIELD];
  logic [bitwidth-1:0] stage_q  [NFIELD];
  logic [bitwidth-1:0] active_q [NFIELD];

  logic config_valid_q, config_valid_d;
  logic update_strobe_q, update_strobe_d;
  logic cfg_rejected_q, cfg_rejected_d;
  logic capture, commit, reject, rules_ok;

  assign cfg_in[0] = cfg_period;
  assign cfg_in[1] = cfg_rise_hs;
  assign cfg_in[2] = cfg_fall_hs;
  assign cfg_in[3] = cfg_rise_ls;
  assign cfg_in[4] = cfg_fall_ls;

  // Staging and active registers, one pair per timing field
  generate
    for (genvar gi = 0; gi < NFIELD; gi++) begin : g_field
      always_ff @(posedge clock) begin
        if (reset) begin
          stage_q[gi]  <= '0;
          active_q[gi] <= '0;
        end else begin
          if (capture) stage_q[gi]  <= cfg_in[gi];
          if (commit)  active_q[gi] <= stage_q[gi];
        end
      end
    end
  endgenerate

  // Ordering rules on the staged set (all unsigned): the high-side pulse
  // ends no later than the low-side pulse starts (dead time may be zero),
  // and the low-side pulse ends within the period.
  assign rules_ok = (stage_q[0] != '0)
                 && (stage_q[1] <  stage_q[2])
                 && (stage_q[2] <= stage_q[3])
                 && (stage_q[3] <  stage_q[4])
                 && (stage_q[4] <= stage_q[0]);

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    commit  = 1'b0;
    reject  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          capture = 1'b1;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (rules_ok) begin
          state_d = PENDING;
        end else begin
          reject  = 1'b1;
          state_d = IDLE;
        end
      end
      PENDING: begin
        // Abort wins over a coincident period_end. With nothing running yet
        // there is no period boundary to wait for, so commit immediately.
        if (cfg_abort) begin
          state_d = IDLE;
        end else if (!config_valid_q || period_end) begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign config_valid_d  = config_valid_q | commit;
  assign update_strobe_d = commit;
  assign cfg_rejected_d  = reject;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      config_valid_q  <= 1'b0;
      update_strobe_q <= 1'b0;
      cfg_rejected_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      config_valid_q  <= config_valid_d;
      update_strobe_q <= update_strobe_d;
      cfg_rejected_q  <= cfg_rejected_d;
    end
  end

`ifdef PWM_CONFIG_SCHEDULER_REJECT_COUNT_EN
  logic [7:0] reject_count_q, reject_count_d;

  // Counts on the same edge that raises cfg_rejected, so it tracks pulses
  always_comb begin
    reject_count_d = reject_count_q;
    if (reject && (reject_count_q != 8'hFF)) reject_count_d = reject_count_q + 8'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) reject_count_q <= 8'd0;
    else       reject_count_q <= reject_count_d;
  end

  assign reject_count = reject_count_q;
`endif

  assign cfg_ready                         = (state_q == IDLE);
  assign pending                           = (state_q == PENDING);
  assign configuration_valid               = config_valid_q;
  assign update_strobe                     = update_strobe_q;
  assign cfg_rejected                      = cfg_rejected_q;
  assign tick_count_period                 = active_q[0];
  assign tick_number_rising_edge_highside  = active_q[1];
  assign tick_number_falling_edge_highside = active_q[2];
  assign tick_number_rising_edge_lowside   = active_q[3];
  assign tick_number_falling_edge_lowside  = active_q[4];

endmodule

// File: tb/tb_pwm_config_scheduler.sv
// -----------------------------------------------------------------------------
// tb_pwm_config_scheduler
//
// Self-checking bench for pwm_config_scheduler: a directed table of timing
// sets, hand-written reset/abort sequences, and randomized offers checked
// against a transaction-level model of the active set.
// -----------------------------------------------------------------------------
module tb_pwm_config_scheduler;

  typedef struct packed {
    logic [7:0] p;
    logic [7:0] rh;
    logic [7:0] fh;
    logic [7:0] rl;
    logic [7:0] fl;
  } cfg_t;

  typedef struct {
    cfg_t c;
    bit   exp_ok;
    int   pe_wait;
    bit   abort_at_pe;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_period, cfg_rise_hs, cfg_fall_hs, cfg_rise_ls, cfg_fall_ls;
  logic       cfg_abort;
  logic       period_end;
  logic [7:0] tick_count_period;
  logic [7:0] tick_number_rising_edge_highside;
  logic [7:0] tick_number_falling_edge_highside;
  logic [7:0] tick_number_rising_edge_lowside;
  logic [7:0] tick_number_falling_edge_lowside;
  logic       configuration_valid;
  logic       update_strobe;
  logic       cfg_rejected;
  logic       pending;
`ifdef PWM_CONFIG_SCHEDULER_REJECT_COUNT_EN
  logic [7:0] reject_count;
`endif

  always #5 clock = ~clock;

  pwm_config_scheduler #(.bitwidth(8)) dut (
    .clock                             (clock),
    .reset                             (reset),
    .cfg_valid                         (cfg_valid),
    .cfg_ready                         (cfg_ready),
    .cfg_period                        (cfg_period),
    .cfg_rise_hs                       (cfg_rise_hs),
    .cfg_fall_hs                       (cfg_fall_hs),
    .cfg_rise_ls                       (cfg_rise_ls),
    .cfg_fall_ls                       (cfg_fall_ls),
    .cfg_abort                         (cfg_abort),
    .period_end                        (period_end),
    .tick_count_period                 (tick_count_period),
    .tick_number_rising_edge_highside  (tick_number_rising_edge_highside),
    .tick_number_falling_edge_highside (tick_number_falling_edge_highside),
    .tick_number_rising_edge_lowside   (tick_number_rising_edge_lowside),
    .tick_number_falling_edge_lowside  (tick_number_falling_edge_lowside),
    .configuration_valid               (configuration_valid),
    .update_strobe                     (update_strobe),
    .cfg_rejected                      (cfg_rejected),
`ifdef PWM_CONFIG_SCHEDULER_REJECT_COUNT_EN
    .reject_count                      (reject_count),
`endif
    .pending                           (pending)
  );

  int   n_vec  = 0;
  int   n_miss = 0;
  int   n_txn  = 0;

  // Reference model: the set the PWM generator should see, whether any set
  // is live, and how many offers have been refused.
  cfg_t m_act;
  bit   m_cv;
  int   m_rej;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic bit ref_ok(input cfg_t c);
    return (c.p != 0) && (c.rh < c.fh) && (c.fh <= c.rl) && (c.rl < c.fl) && (c.fl <= c.p);
  endfunction

  task automatic chk_active(input string tag);
    chk({tag, ".period"},  {24'd0, tick_count_period},                 {24'd0, m_act.p});
    chk({tag, ".rise_hs"}, {24'd0, tick_number_rising_edge_highside},  {24'd0, m_act.rh});
    chk({tag, ".fall_hs"}, {24'd0, tick_number_falling_edge_highside}, {24'd0, m_act.fh});
    chk({tag, ".rise_ls"}, {24'd0, tick_number_rising_edge_lowside},   {24'd0, m_act.rl});
    chk({tag, ".fall_ls"}, {24'd0, tick_number_falling_edge_lowside},  {24'd0, m_act.fl});
    chk({tag, ".cfg_valid_out"}, {31'd0, configuration_valid}, {31'd0, m_cv});
`ifdef PWM_CONFIG_SCHEDULER_REJECT_COUNT_EN
    chk({tag, ".reject_count"}, {24'd0, reject_count}, m_rej);
`endif
  endtask

  task automatic chk_ctl(input string tag, input bit rdy, input bit pnd, input bit stb, input bit rej);
    chk({tag, ".ready"},    {31'd0, cfg_ready},     {31'd0, rdy});
    chk({tag, ".pending"},  {31'd0, pending},       {31'd0, pnd});
    chk({tag, ".strobe"},   {31'd0, update_strobe}, {31'd0, stb});
    chk({tag, ".rejected"}, {31'd0, cfg_rejected},  {31'd0, rej});
  endtask

  task automatic drive_quiet();
    cfg_valid  = 1'b0;
    cfg_abort  = 1'b0;
    period_end = 1'b0;
  endtask

  // Garbage on every input the block must ignore in CHECK/PENDING waits
  task automatic scramble(input bit allow_abort);
    cfg_period  = 8'($urandom);
    cfg_rise_hs = 8'($urandom);
    cfg_fall_hs = 8'($urandom);
    cfg_rise_ls = 8'($urandom);
    cfg_fall_ls = 8'($urandom);
    cfg_valid   = 1'($urandom);
    cfg_abort   = allow_abort ? 1'($urandom) : 1'b0;
    period_end  = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    drive_quiet();
    step();
    m_act = '0;
    m_cv  = 1'b0;
    m_rej = 0;
    chk_active({tag, ".in_reset"});
    chk_ctl({tag, ".in_reset"}, 1'b1, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    step();
    chk_ctl({tag, ".released"}, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Offer one set and follow it through check and commit (or reject/abort).
  // Called with the DUT idle, at #1 after an edge.
  task automatic offer(input cfg_t c, input bit exp_ok, input int pe_wait, input bit abort_at_pe);
    string tag;
    n_txn++;
    tag = $sformatf("txn%0d", n_txn);
    $display("txn %0d: offer %0d/%0d/%0d/%0d/%0d expect_ok=%0b wait=%0d abort=%0b",
             n_txn, c.p, c.rh, c.fh, c.rl, c.fl, exp_ok, pe_wait, abort_at_pe);
    chk({tag, ".ready_before"}, {31'd0, cfg_ready}, 32'd1);
    cfg_valid   = 1'b1;
    cfg_abort   = 1'b0;
    period_end  = 1'b0;
    cfg_period  = c.p;
    cfg_rise_hs = c.rh;
    cfg_fall_hs = c.fh;
    cfg_rise_ls = c.rl;
    cfg_fall_ls = c.fl;
    step();
    // Check cycle: ready low, abort/period_end/new cfg values must be ignored
    chk_ctl({tag, ".check"}, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_active({tag, ".check"});
    scramble(1'b1);
    period_end = 1'($urandom);
    step();
    drive_quiet();
    if (!exp_ok) begin
      m_rej = (m_rej == 255) ? 255 : m_rej + 1;
      chk_ctl({tag, ".reject"}, 1'b1, 1'b0, 1'b0, 1'b1);
      chk_active({tag, ".reject"});
      return;
    end
    chk_ctl({tag, ".pend"}, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_active({tag, ".pend"});
    if (m_cv) begin
      for (int i = 0; i < pe_wait; i++) begin
        scramble(1'b0);
        step();
        chk_ctl({tag, ".wait"}, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_active({tag, ".wait"});
      end
      drive_quiet();
      period_end = 1'b1;
      cfg_abort  = abort_at_pe;
    end
    step();
    drive_quiet();
    if (m_cv && abort_at_pe) begin
      chk_ctl({tag, ".abort"}, 1'b1, 1'b0, 1'b0, 1'b0);
      chk_active({tag, ".abort"});
    end else begin
      m_act = c;
      m_cv  = 1'b1;
      chk_ctl({tag, ".commit"}, 1'b1, 1'b0, 1'b1, 1'b0);
      chk_active({tag, ".commit"});
    end
  endtask

  vec_t tbl[7];

  initial begin
    cfg_t rc;
    int   p, fl, rl, fh;

    tbl[0] = '{'{8'd100, 8'd10, 8'd40, 8'd50, 8'd90},  1'b1, 0,  1'b0};
    tbl[1] = '{'{8'd200, 8'd20, 8'd60, 8'd80, 8'd180}, 1'b1, 10, 1'b0};
    tbl[2] = '{'{8'd100, 8'd40, 8'd40, 8'd50, 8'd90},  1'b0, 0,  1'b0};
    tbl[3] = '{'{8'd0,   8'd0,  8'd0,  8'd0,  8'd0},   1'b0, 0,  1'b0};
    tbl[4] = '{'{8'd100, 8'd10, 8'd40, 8'd50, 8'd101}, 1'b0, 0,  1'b0};
    tbl[5] = '{'{8'd100, 8'd10, 8'd40, 8'd40, 8'd100}, 1'b1, 3,  1'b0};
    tbl[6] = '{'{8'd50,  8'd1,  8'd2,  8'd3,  8'd4},   1'b1, 2,  1'b1};

    reset = 1'b1;
    drive_quiet();
    cfg_period  = 8'd0;
    cfg_rise_hs = 8'd0;
    cfg_fall_hs = 8'd0;
    cfg_rise_ls = 8'd0;
    cfg_fall_ls = 8'd0;
    do_reset("reset0");

    for (int i = 0; i < 7; i++) begin
      offer(tbl[i].c, tbl[i].exp_ok, tbl[i].pe_wait, tbl[i].abort_at_pe);
    end

    // Reset while a checked set is waiting: everything clears, and a later
    // period_end must not commit the discarded set.
    cfg_valid   = 1'b1;
    cfg_period  = 8'd90;
    cfg_rise_hs = 8'd5;
    cfg_fall_hs = 8'd30;
    cfg_rise_ls = 8'd35;
    cfg_fall_ls = 8'd80;
    step();
    drive_quiet();
    step();
    $display("seq: reset while pending");
    chk("rst_pend.pending_before", {31'd0, pending}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_act = '0;
    m_cv  = 1'b0;
    m_rej = 0;
    chk_active("rst_pend.after");
    chk_ctl("rst_pend.after", 1'b1, 1'b0, 1'b0, 1'b0);
    period_end = 1'b1;
    step();
    period_end = 1'b0;
    chk_active("rst_pend.pe");
    chk_ctl("rst_pend.pe", 1'b1, 1'b0, 1'b0, 1'b0);

    // Randomized offers against the model, with idle gaps carrying stray
    // period_end/abort pulses that must change nothing.
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        p  = int'($urandom_range(3, 255));
        fl = int'($urandom_range(2, p));
        rl = int'($urandom_range(1, fl - 1));
        fh = int'($urandom_range(1, rl));
        rc = '{8'(p), 8'($urandom_range(0, fh - 1)), 8'(fh), 8'(rl), 8'(fl)};
      end else begin
        rc = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
      end
      offer(rc, ref_ok(rc), int'($urandom_range(0, 5)), ($urandom_range(0, 4) == 0));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        cfg_valid  = 1'b0;
        period_end = 1'($urandom);
        cfg_abort  = 1'($urandom);
        step();
        drive_quiet();
        chk("idle.ready",   {31'd0, cfg_ready}, 32'd1);
        chk("idle.pending", {31'd0, pending},   32'd0);
        chk_active("idle");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/pwm_config_scheduler.md
PWM_CONFIG_SCHEDULER -- requirements
Module: pwm_config_scheduler

Interface
REQ-001 The block SHALL have parameter bitwidth, default 8, the width of every timing value.
REQ-002 The block SHALL have port clock, input, 1, the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-004 The block SHALL have port cfg_valid, input, 1, the requester's offer of a new timing set.
REQ-005 The block SHALL have port cfg_ready, output, 1, high when a set can be accepted.
REQ-006 The block SHALL have ports cfg_period, cfg_rise_hs, cfg_fall_hs, cfg_rise_ls and cfg_fall_ls, each input, bitwidth wide, carrying the offered timing set.
REQ-007 The block SHALL have port cfg_abort, input, 1, which drops a staged but not yet committed set.
REQ-008 The block SHALL have port period_end, input, 1, a one-cycle pulse from the PWM counter on its last tick of a period.
REQ-009 The block SHALL have ports tick_count_period, tick_number_rising_edge_highside, tick_number_falling_edge_highside, tick_number_rising_edge_lowside and tick_number_falling_edge_lowside, each output, bitwidth wide, carrying the active set sent to the PWM generator.
REQ-010 The block SHALL have port configuration_valid, output, 1, high once any valid set is active.
REQ-011 The block SHALL have port update_strobe, output, 1, a one-cycle pulse marking that the active set changed.
REQ-012 The block SHALL have port cfg_rejected, output, 1, a one-cycle pulse marking that an offered set failed validation.
REQ-013 The block SHALL have port pending, output, 1, high while a validated set waits to commit.

Function
REQ-014 The controller SHALL be a state machine with states IDLE, CHECK and PENDING.
REQ-015 cfg_ready SHALL be high exactly when the state is IDLE, decoded combinationally from state.
REQ-016 In IDLE with cfg_valid=1, the controller SHALL capture all five cfg_* values into staging registers at the clock edge and go to CHECK.
REQ-017 CHECK SHALL last one cycle and evaluate the staged set using unsigned comparisons: period>0; rise_hs<fall_hs; fall_hs<=rise_ls; rise_ls<fall_ls; fall_ls<=period.
REQ-018 If all CHECK rules hold, the next state SHALL be PENDING.
REQ-019 If any CHECK rule fails, the next state SHALL be IDLE, cfg_rejected SHALL pulse for the following cycle, and the active set SHALL remain unchanged.
REQ-020 In PENDING, pending SHALL be 1; in every other state, pending SHALL be 0.
REQ-021 In PENDING with configuration_valid=1, the staged set SHALL be copied to the active outputs at the first edge where period_end=1; the next state SHALL be IDLE.
REQ-022 In PENDING with configuration_valid=0, the commit SHALL occur at the next edge regardless of period_end.
REQ-023 On commit, update_strobe SHALL be 1 for exactly the following cycle, and configuration_valid SHALL be set to 1 and stay 1 until reset.
REQ-024 Minimum latency from the accepting edge to the active outputs changing SHALL be 2 edges when nothing is active yet; otherwise it is 2 edges plus the wait for period_end.
REQ-025 cfg_abort=1 in PENDING SHALL return the state to IDLE without a commit; if cfg_abort and period_end are both 1 in the same cycle, abort SHALL take priority.
REQ-026 cfg_abort SHALL be ignored in IDLE and CHECK.
REQ-027 period_end SHALL be ignored outside PENDING.
REQ-028 The active outputs SHALL never change except on a commit edge, so the active set never changes mid-period once running.
REQ-029 cfg_* values SHALL be sampled only on the accepting edge; later changes SHALL have no effect on the staged set.

Reset
REQ-030 With reset=1 at an edge, the state SHALL be IDLE; all five active outputs, the staging registers, configuration_valid, update_strobe, cfg_rejected and pending SHALL be 0.
REQ-031 Reset SHALL take priority over every other input, including mid-CHECK and mid-PENDING, discarding any staged set.
REQ-032 cfg_ready SHALL read 1 in the first cycle after reset is released.

Configuration
REQ-033 With macro PWM_CONFIG_SCHEDULER_REJECT_COUNT_EN defined, the block SHALL add output reject_count, 8 bits wide, counting cfg_rejected pulses, saturating at 255 and cleared by reset.
REQ-034 Without the macro, reject_count and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-035 After reset, offer 100/10/40/50/90 (period/rise_hs/fall_hs/rise_ls/fall_ls) -> active outputs equal these 2 edges after acceptance, update_strobe pulses once, configuration_valid=1, and period_end is not needed.
REQ-036 With that set active, offer 200/20/60/80/180 -> pending=1; outputs keep the old set until period_end is pulsed 10 cycles later; they change on that edge; update_strobe pulses.
REQ-037 Offer 100/40/40/50/90 -> cfg_rejected pulses once, the active set is unchanged, the state returns to IDLE, and reject_count increments when the macro is defined.
REQ-038 Offer 0/0/0/0/0 -> rejected; offer 100/10/40/50/101 -> rejected; offer 100/10/40/40/100 -> accepted (equality boundaries).
REQ-039 In PENDING, assert cfg_abort and period_end in the same cycle -> no commit, no update_strobe, IDLE with cfg_ready=1.
REQ-040 Assert reset while in PENDING -> all outputs read 0 on the next cycle, and a following period_end causes no commit.
